switch_debouncer: RTL
=====================

# switch_debouncer

Input-side conditioning block for the board slide switches. Synchronizes each raw switch bit to `clk`, filters contact bounce with a per-bit stability counter, and presents clean levels plus single-cycle rise/fall pulses. It sits between the board switch pins and all switch-consuming logic, including the stair-light, adder and full-adder functions, and the LED-driving logic downstream of them.

## Interface
Parameters:
- `WIDTH`, 8: number of switch bits conditioned.
- `STABLE_CYCLES`, 1_000_000: consecutive synchronized cycles a new level must hold before acceptance (10 ms at 100 MHz); legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `sw_raw`  input  WIDTH  asynchronous switch pins.
- `sw_clean`  output  WIDTH  debounced switch levels; reset value all 0.
- `sw_rise`  output  WIDTH  one-cycle pulse per bit on a clean 0→1 transition; reset value 0.
- `sw_fall`  output  WIDTH  one-cycle pulse per bit on a clean 1→0 transition; reset value 0.
- `changed`  output  1  OR-reduction of `sw_rise | sw_fall`, registered with them; reset value 0.

## Operation
- Per bit, a two-flop synchronizer (`sync1`, `sync2`) samples `sw_raw`. Both flops reset to 0.
- Per bit, a counter of width max(1, $clog2(STABLE_CYCLES)) resets to 0.
- Each rising edge, independently per bit:
  - If `sync2 == sw_clean`, the counter clears to 0.
  - If `sync2 != sw_clean` and the counter is below STABLE_CYCLES-1, the counter increments.
  - If `sync2 != sw_clean` and the counter equals STABLE_CYCLES-1, then `sw_clean <= sync2` and the counter clears to 0. On the same edge, `sw_rise` is set to 1 if the new value is 1, otherwise `sw_fall` is set to 1.
- `sw_rise` and `sw_fall` are otherwise 0, so each pulse lasts exactly one cycle and coincides with the first cycle `sw_clean` shows the new value.
- A glitch or bounce returning to the clean level before acceptance clears the counter. No output change and no pulse occurs, and a later change restarts counting from 0.
- Bits are fully independent. Any number of bits may update and pulse in the same cycle, and `changed` is 1 in that cycle.
- `rst` asserted (sampled at a rising edge, including mid-count or mid-pulse): all synchronizers, counters, `sw_clean`, pulses and `changed` go to 0 on that edge. No fall pulse is generated for bits forced low by reset. Switches held high through reset produce a normal rise pulse after the full latency once `rst` deasserts.
- The counter never exceeds STABLE_CYCLES-1 and never wraps.

## Timing
- Latency: a raw level first sampled by `sync1` at edge k, and held, appears on `sw_clean` and the pulse outputs after edge k+1+STABLE_CYCLES.
  - This is STABLE_CYCLES+2 edges in total.
  - With STABLE_CYCLES = 1 this is 3 edges.
- Minimum accepted pulse width on `sw_raw`: STABLE_CYCLES synchronized cycles. Anything shorter is rejected.
- Minimum spacing between two pulses on the same bit: STABLE_CYCLES cycles.
- All outputs are registered. There is no combinational path from `sw_raw` or `rst` to any output.

## Test plan
Run with WIDTH = 8 and STABLE_CYCLES = 4 (latency 6 edges).
- Reset: hold `rst` for 3 cycles with `sw_raw` = 0xFF, then release → all outputs 0 during reset. `sw_clean` = 0xFF and `sw_rise` = 0xFF for exactly one cycle, 6 edges after the first post-reset sample; `changed` = 1 in that same cycle.
- Clean edge: raise `sw_raw[0]` and hold → `sw_clean[0]` = 1 and `sw_rise[0]` pulses for one cycle 6 edges later. Lowering it yields `sw_fall[0]` with the same latency.
- Bounce rejection: toggle `sw_raw[3]` 1,0,1,0 on consecutive cycles, each level held 2 cycles, then leave it at 0 → `sw_clean[3]` stays 0, no pulses, `changed` stays 0.
- Bounce then settle: apply 3 cycles of 1/0 chatter on `sw_raw[5]`, then a steady 1 → `sw_rise[5]` pulses exactly once, 6 edges after the steady 1 is first sampled.
- Simultaneous events: raise bits 1 and 6 and lower bit 2 (previously clean 1) on the same edge → `sw_rise` = 0x42 and `sw_fall` = 0x04 in the same cycle, with `changed` = 1 for one cycle only.
- Reset mid-count: raise `sw_raw[7]` and assert `rst` 3 edges later → no pulse, `sw_clean[7]` = 0. After deassertion with the bit still high, the rise arrives a full 6 edges later.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Switch-side bus of the debouncer: raw pins in, clean levels and edge pulses out.
// The slave modport is the debouncer; the master is whatever drives the pins and consumes the results.
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit switch conditioner: two-flop synchronizer, stability counter, clean level and one-cycle edge pulses.
// The WIDTH parameter must match the WIDTH of the connected switch_debouncer_if instance.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  switch_debouncer_if.slave  bus
);
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= bus.sw_raw;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= |(rise_d | fall_d);
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          differ;
      logic          accept;

      // A level is accepted on the edge where it has already differed for STABLE_CYCLES-1 counts.
      assign differ      = sync2_q[gi] ^ clean_q[gi];
      assign accept      = differ && (cnt_q == CNT_MAX);
      assign clean_d[gi] = accept ? sync2_q[gi] : clean_q[gi];
      assign rise_d[gi]  = accept & sync2_q[gi];
      assign fall_d[gi]  = accept & ~sync2_q[gi];

      always_comb begin
        cnt_d = '0;
        if (differ && !accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign bus.sw_clean = clean_q;
  assign bus.sw_rise  = rise_q;
  assign bus.sw_fall  = fall_q;
  assign bus.changed  = changed_q;
endmodule
